// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, stall reasons
// and the stage-control bundle that each stall reason maps onto.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0 = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MEM      = 2'd1,
    MISPRED  = 2'd2,
    LOAD_USE = 2'd3
  } stall_reason_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic redirect;
  } ctrl_t;

  // Map the winning hazard onto the register enables and flushes.
  function automatic ctrl_t ctrl_for(input stall_reason_e reason);
    ctrl_t c;
    c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
          idex_flush: 1'b0, exmem_en: 1'b1, redirect: 1'b0};
    case (reason)
      MEM:      c = '0;
      MISPRED:  c = '1;
      LOAD_USE: c = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
                      idex_flush: 1'b1, exmem_en: 1'b1, redirect: 1'b0};
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use comparator: the instruction in IF/ID reads the register that the
// load currently in ID/EX has not yet produced. Writes to x0 never hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_uses_rs1,
  input  logic                 ifid_uses_rs2,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 idex_mem_read,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = ifid_uses_rs1 && (ifid_rs1 == idex_rd);
  assign rs2_hit  = ifid_uses_rs2 && (ifid_rs2 == idex_rd);
  assign load_use = idex_mem_read && (idex_rd != X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait FSM with
// timeout, mispredict flush, load-use bubble, and saturating perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_uses_rs1,
  input  logic                 ifid_uses_rs2,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 idex_mem_read,
  input  logic                 ex_mispredict,
  input  logic                 exmem_mem_req,
  input  logic                 dmem_ack,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 redirect,
  output logic                 mem_timeout_err,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  state_e            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_hit;
  logic              mem_stall;
  logic              load_use;
  stall_reason_e     reason;
  ctrl_t             ctrl;

  load_use_detect u_load_use (
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs1 (ifid_uses_rs1),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .load_use      (load_use)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_hit   = 1'b0;
    mem_stall     = 1'b0;
    case (state)
      RUN: begin
        // A same-cycle ack is a zero-wait access and never leaves RUN.
        mem_stall = exmem_mem_req && !dmem_ack;
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        timeout_hit = !dmem_ack && (wait_cnt == WAIT_LAST);
        mem_stall   = !dmem_ack && !timeout_hit;
        if (dmem_ack || timeout_hit) state_next = RUN;
        else                         wait_cnt_next = wait_cnt + WAIT_W'(1);
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    if (mem_stall)          reason = MEM;
    else if (ex_mispredict) reason = MISPRED;
    else if (load_use)      reason = LOAD_USE;
    else                    reason = NONE;
  end

  // Reset must force the stage controls low at once, not at the next edge.
  assign ctrl = rst ? ctrl_for(reason) : '0;

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign idex_flush = ctrl.idex_flush;
  assign exmem_en   = ctrl.exmem_en;
  assign redirect   = ctrl.redirect;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_hit) mem_timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (ctrl.redirect && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second narrow-counter instance
// exercises counter saturation alongside the main instance.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs1, ifid_uses_rs2, idex_mem_read;
  logic       ex_mispredict, exmem_mem_req, dmem_ack;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, redirect;
  logic        mem_timeout_err;
  logic [31:0] stall_cycles, flush_events;

  logic       s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_redirect;
  logic       s_err;
  logic [2:0] s_stall, s_flush;

  logic [6:0] outs;
  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, redirect};

  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_RUN  = 7'b1101010;
  localparam logic [6:0] O_MISP = 7'b1111111;
  localparam logic [6:0] O_LU   = 7'b0001110;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_mispredict(ex_mispredict), .exmem_mem_req(exmem_mem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .redirect(redirect), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_mispredict(ex_mispredict), .exmem_mem_req(exmem_mem_req), .dmem_ack(dmem_ack),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_en(s_idex_en), .idex_flush(s_idex_flush), .exmem_en(s_exmem_en),
    .redirect(s_redirect), .mem_timeout_err(s_err),
    .stall_cycles(s_stall), .flush_events(s_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    ex_mispredict = 1'b0; exmem_mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    idex_mem_read = 1'b1; idex_rd = rd;
    ifid_rs1 = rs1; ifid_uses_rs1 = u1;
    ifid_rs2 = rs2; ifid_uses_rs2 = u2;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    exmem_mem_req = 1'b1;
    ex_mispredict = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL reset_outs: got %b want %b", outs, O_IDLE); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    total++; if (flush_events !== 32'd0) begin bad++; $display("FAIL reset_flush: got %0d want 0", flush_events); end
    total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", mem_timeout_err); end
    do_reset();
  endtask

  task automatic test_independent();
    // addi x10,x0,2 in ID/EX, addi x11,x0,2 in IF/ID
    idex_rd = 5'd10; idex_mem_read = 1'b0;
    ifid_rs1 = 5'd0; ifid_uses_rs1 = 1'b1; ifid_rs2 = 5'd2; ifid_uses_rs2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (outs !== O_RUN) begin bad++; $display("FAIL indep_outs[%0d]: got %b want %b", c, outs, O_RUN); end
      tick();
    end
    @(negedge clk);
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL indep_stall: got %0d want 0", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd10, 5'd10, 1'b1, 5'd11, 1'b1);
    @(negedge clk);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs1: got %b want %b", outs, O_LU); end
    tick();
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL lu_after: got %b want %b", outs, O_RUN); end
    total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL lu_stall1: got %0d want 1", stall_cycles); end
    tick();
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL lu_x0: got %b want %b", outs, O_RUN); end
    tick();
    set_load_use(5'd10, 5'd5, 1'b1, 5'd10, 1'b1);
    @(negedge clk);
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs2: got %b want %b", outs, O_LU); end
    tick();
    ifid_uses_rs2 = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL lu_rs2_unused: got %b want %b", outs, O_RUN); end
    tick();
    clear_inputs();
    @(negedge clk);
    total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL lu_stall2: got %0d want 2", stall_cycles); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    exmem_mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      @(negedge clk);
      total++;
      if (outs !== ((c == 3) ? O_RUN : O_IDLE)) begin
        bad++; $display("FAIL memwait_outs[%0d]: got %b want %b", c, outs, (c == 3) ? O_RUN : O_IDLE);
      end
      tick();
    end
    exmem_mem_req = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL memwait_resume: got %b want %b", outs, O_RUN); end
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL memwait_stall: got %0d want 3", stall_cycles); end
    tick();
    exmem_mem_req = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL zero_wait: got %b want %b", outs, O_RUN); end
    tick();
    exmem_mem_req = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL zero_wait_run: got %b want %b", outs, O_RUN); end
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL zero_wait_stall: got %0d want 3", stall_cycles); end
    tick();
  endtask

  task automatic test_timeout_back_to_back();
    do_reset();
    exmem_mem_req = 1'b1;
    // Two consecutive timeouts: 4 stalls, one advance, repeated.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (outs !== ((c == 4 || c == 9) ? O_RUN : O_IDLE)) begin
        bad++; $display("FAIL timeout_outs[%0d]: got %b want %b", c, outs, (c == 4 || c == 9) ? O_RUN : O_IDLE);
      end
      total++;
      if (mem_timeout_err !== (c >= 5)) begin
        bad++; $display("FAIL timeout_err[%0d]: got %b want %b", c, mem_timeout_err, c >= 5);
      end
      tick();
    end
    exmem_mem_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (outs !== O_RUN) begin bad++; $display("FAIL timeout_run[%0d]: got %b want %b", c, outs, O_RUN); end
      total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky[%0d]: got %b want 1", c, mem_timeout_err); end
      tick();
    end
    total++; if (stall_cycles !== 32'd8) begin bad++; $display("FAIL timeout_stall: got %0d want 8", stall_cycles); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_load_use(5'd10, 5'd10, 1'b1, 5'd11, 1'b1);
    ex_mispredict = 1'b1;
    @(negedge clk);
    total++; if (outs !== O_MISP) begin bad++; $display("FAIL mispred_lu: got %b want %b", outs, O_MISP); end
    tick();
    clear_inputs();
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL mispred_after: got %b want %b", outs, O_RUN); end
    total++; if (flush_events !== 32'd1) begin bad++; $display("FAIL mispred_flush1: got %0d want 1", flush_events); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL mispred_stall0: got %0d want 0", stall_cycles); end
    tick();
    exmem_mem_req = 1'b1; ex_mispredict = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dmem_ack = (c == 2);
      @(negedge clk);
      total++;
      if (outs !== ((c == 2) ? O_MISP : O_IDLE)) begin
        bad++; $display("FAIL mispred_memwait[%0d]: got %b want %b", c, outs, (c == 2) ? O_MISP : O_IDLE);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    total++; if (flush_events !== 32'd2) begin bad++; $display("FAIL mispred_flush2: got %0d want 2", flush_events); end
    total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL mispred_stall2: got %0d want 2", stall_cycles); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    // One timeout (err set), then a fresh wait held 2 cycles into MEM_WAIT.
    exmem_mem_req = 1'b1;
    repeat (8) tick();
    total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL abort_pre_err: got %b want 1", mem_timeout_err); end
    total++; if (stall_cycles !== 32'd7) begin bad++; $display("FAIL abort_pre_stall: got %0d want 7", stall_cycles); end
    ex_mispredict = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    total++; if (outs !== O_IDLE) begin bad++; $display("FAIL abort_outs: got %b want %b", outs, O_IDLE); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL abort_stall: got %0d want 0", stall_cycles); end
    total++; if (flush_events !== 32'd0) begin bad++; $display("FAIL abort_flush: got %0d want 0", flush_events); end
    total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", mem_timeout_err); end
    @(negedge clk);
    clear_inputs();
    dmem_ack = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL late_ack: got %b want %b", outs, O_RUN); end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL abort_run: got %b want %b", outs, O_RUN); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL abort_run_stall: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    repeat (10) tick();
    clear_inputs();
    ex_mispredict = 1'b1;
    repeat (10) tick();
    clear_inputs();
    @(negedge clk);
    total++; if (stall_cycles !== 32'd10) begin bad++; $display("FAIL sat_stall_wide: got %0d want 10", stall_cycles); end
    total++; if (flush_events !== 32'd10) begin bad++; $display("FAIL sat_flush_wide: got %0d want 10", flush_events); end
    total++; if (s_stall !== 3'd7) begin bad++; $display("FAIL sat_stall_narrow: got %0d want 7", s_stall); end
    total++; if (s_flush !== 3'd7) begin bad++; $display("FAIL sat_flush_narrow: got %0d want 7", s_flush); end
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_independent();
    test_load_use();
    test_mem_wait();
    test_timeout_back_to_back();
    test_mispredict();
    test_reset_in_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the RV32I 5-stage pipeline. Drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three hazard classes: load-use, data-memory wait (req/ack handshake with timeout) and branch misprediction. It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM_WAIT before the timeout error is raised (>=1)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
ifid_rs1  input  5  rs1 field of the instruction in IF/ID
ifid_rs2  input  5  rs2 field of the instruction in IF/ID
ifid_uses_rs1  input  1  the decoded instruction reads rs1
ifid_uses_rs2  input  1  the decoded instruction reads rs2
idex_rd  input  5  rd held in ID/EX
idex_mem_read  input  1  the ID/EX instruction is a load (IDEXMemRead)
ex_mispredict  input  1  EX resolved a branch/jump opposite to its prediction
exmem_mem_req  input  1  the EX/MEM instruction issues a data-memory request
dmem_ack  input  1  data memory completes the current request (1-cycle pulse)
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID enable
ifid_flush  output  1  IF/ID flush (load a NOP)
idex_en  output  1  ID/EX enable
idex_flush  output  1  ID/EX flush (load a bubble)
exmem_en  output  1  EX/MEM enable
redirect  output  1  select the EX-computed target for the PC
mem_timeout_err  output  1  sticky; set on a MEM_WAIT timeout
stall_cycles  output  CNT_W  count of cycles with pc_en=0
flush_events  output  CNT_W  count of mispredict flushes

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, mem_timeout_err=0, both perf counters=0.
- While rst=0 all enables=0, flushes=0, redirect=0.
- load_use = idex_mem_read & idex_rd!=0 & ((ifid_uses_rs1 & rs1==rd) | (ifid_uses_rs2 & rs2==rd)).
- FSM states: RUN, MEM_WAIT.
- RUN -> MEM_WAIT when exmem_mem_req=1 and dmem_ack=0.
- A same-cycle ack is a 0-wait access: the FSM stays in RUN.
- MEM_WAIT -> RUN in the cycle after dmem_ack=1.
- MEM_WAIT -> RUN when the wait counter reaches MEM_TIMEOUT-1 without an ack. That transition also sets mem_timeout_err, and the pipeline resumes.
- The wait counter clears on entry to MEM_WAIT.
- Output priority, highest first:
  1. Memory stall: (state==RUN & exmem_mem_req & !dmem_ack), or MEM_WAIT without ack/timeout. All enables=0, no flush, redirect=0. A mispredict in EX is held in ID/EX and re-evaluated once the stall ends.
  2. Mispredict: all enables=1, ifid_flush=1, idex_flush=1, redirect=1. A coincident load_use is ignored because that instruction is squashed.
  3. Load-use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. Lasts exactly 1 cycle, since the load then advances.
  4. Otherwise: all enables=1, no flush, redirect=0.
- In the ack cycle in MEM_WAIT, outputs follow priorities 2-4, i.e. the pipeline advances in that cycle.
- stall_cycles increments on every cycle with rst=1 and pc_en=0. It saturates at all-ones.
- flush_events increments on every cycle with redirect=1. It saturates at all-ones.
- mem_timeout_err clears only on reset.
- Reset asserted in MEM_WAIT aborts the wait immediately. No ack is expected afterwards, and a late ack in RUN without a request is ignored.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN=0, MEM_WAIT=1);
  - the stall-reason encoding (NONE, MEM, MISPRED, LOAD_USE);
  - the register index width (5) and the x0 constant.
- One natural sub-module, load_use_detect: purely combinational comparator producing load_use.

Test Plan:
- Reset, then independent instructions 0x00200513 -> 0x00200593 with no loads. Required: all enables=1, no flushes, stall_cycles=0.
- ID/EX holds `lw x10` (idex_mem_read=1, rd=10); IF/ID holds `add x12,x10,x11` (rs1=10, uses_rs1=1). Required: exactly 1 cycle of pc_en=0/ifid_en=0/idex_flush=1, then normal flow, stall_cycles=1. The same stimulus with rd=0 produces no stall.
- exmem_mem_req=1 with dmem_ack arriving 3 cycles later. Required: enables=0 for 3 cycles, advance in the ack cycle, stall_cycles=3. An ack in the same cycle as the request gives 0 stall.
- MEM_TIMEOUT=4 and no ack. Required: 4 stalled cycles, mem_timeout_err=1 and held, FSM back in RUN.
- ex_mispredict=1 together with load_use=1. Required: ifid_flush=idex_flush=redirect=1, no load-use stall, flush_events=1. The same mispredict during MEM_WAIT produces no flush until the ack cycle.
- rst pulled low 2 cycles into MEM_WAIT. Required: all outputs 0 immediately (async), counters and error cleared, RUN on release.
